// File: rtl/sobel_window_pkg.sv
// Shared constants and types for the sobel window / sobel filter pipeline.
// Window neighbour packing lives here so both stages agree on the byte order.
package sobel_window_pkg;

   localparam int DEF_MAX_COL = 640;
   localparam int DEF_MAX_ROW = 480;
   localparam int PIX_W       = 8;
   localparam int WIN_W       = 64;
   localparam int COORD_W     = 10;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2
   } win_state_e;

   // 3x3 neighbourhood, element index = row*3 + col (row 0 = top, col 0 = left)
   typedef logic [8:0][PIX_W-1:0] win3x3_t;

   // Packs the eight neighbours (centre excluded), zeroing those outside the image.
   function automatic logic [WIN_W-1:0] pack_window(input win3x3_t w,
                                                    input logic    m_top,
                                                    input logic    m_bot,
                                                    input logic    m_left,
                                                    input logic    m_right);
      logic [PIX_W-1:0] tl, t, tr, ml, mr, bl, b, br;
      tl = (m_top | m_left)  ? '0 : w[0];
      t  = m_top             ? '0 : w[1];
      tr = (m_top | m_right) ? '0 : w[2];
      ml = m_left            ? '0 : w[3];
      mr = m_right           ? '0 : w[5];
      bl = (m_bot | m_left)  ? '0 : w[6];
      b  = m_bot             ? '0 : w[7];
      br = (m_bot | m_right) ? '0 : w[8];
      return {tl, t, tr, ml, mr, bl, b, br};
   endfunction

endpackage

// File: rtl/sobel_window_if.sv
// Pixel-in / window-out bus of the sobel window stage.
// Both sides use valid/ready: a transfer happens on a rising edge where valid & ready
// are both high; a source holds its payload stable while valid & ~ready.
interface sobel_window_if;
   import sobel_window_pkg::*;

   logic [PIX_W-1:0]   in_pixel;
   logic               in_valid;
   logic               in_ready;
   logic [WIN_W-1:0]   win_pixels;
   logic [PIX_W-1:0]   win_center;
   logic [COORD_W-1:0] win_row;
   logic [COORD_W-1:0] win_col;
   logic               win_valid;
   logic               win_ready;
   logic               frame_done;

   modport master (
      output in_pixel, in_valid, win_ready,
      input  in_ready, win_pixels, win_center, win_row, win_col, win_valid, frame_done
   );

   modport slave (
      input  in_pixel, in_valid, win_ready,
      output in_ready, win_pixels, win_center, win_row, win_col, win_valid, frame_done
   );

endinterface

// File: rtl/sobel_window_line_ram.sv
// Two-line store for the sobel window: {older line, newer line} per column.
// Combinational read, synchronous write; a same-address read sees the old word.
module sobel_line_ram #(
   parameter int DEPTH = 640,
   parameter int AW    = 10,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata
);

   logic [DW-1:0] mem [DEPTH];

   assign rdata = mem[raddr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/sobel_window.sv
// Raster pixel stream to 3x3 neighbourhood converter feeding the sobel stage.
// A step (real pixel or zero flush pixel) shifts one column into the window.
module sobel_window
   import sobel_window_pkg::*;
#(
   parameter int MAX_COL = DEF_MAX_COL,
   parameter int MAX_ROW = DEF_MAX_ROW
) (
   input  logic          clk,
   input  logic          reset,
   sobel_window_if.slave win_if,
   output win_state_e    state_dbg
);

   localparam int AW = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
   localparam int SW = $clog2(MAX_COL + 2);
   localparam logic [COORD_W-1:0] LAST_COL  = COORD_W'(MAX_COL - 1);
   localparam logic [COORD_W-1:0] LAST_ROW  = COORD_W'(MAX_ROW - 1);
   localparam logic [SW-1:0]      STEP_LAST = SW'(MAX_COL);

   win_state_e         state_q, state_d;
   logic [COORD_W-1:0] in_col_q, in_col_d;
   logic [COORD_W-1:0] in_row_q, in_row_d;
   logic [COORD_W-1:0] out_col_q, out_col_d;
   logic [COORD_W-1:0] out_row_q, out_row_d;
   logic [SW-1:0]      step_cnt_q, step_cnt_d;
   win3x3_t            win_q, win_d;
   logic [WIN_W-1:0]   win_pixels_q, win_pixels_d;
   logic [PIX_W-1:0]   win_center_q, win_center_d;
   logic [COORD_W-1:0] win_row_q, win_row_d;
   logic [COORD_W-1:0] win_col_q, win_col_d;
   logic               win_valid_q, win_valid_d;
   logic               win_last_q, win_last_d;

   win3x3_t            win_nxt;
   logic               out_free;
   logic               in_ready;
   logic               step_in;
   logic               step_flush;
   logic               step;
   logic               emit;
   logic [PIX_W-1:0]   step_pix;
   logic [2*PIX_W-1:0] ram_rdata;
   logic [2*PIX_W-1:0] ram_wdata;

   sobel_line_ram #(
      .DEPTH (MAX_COL),
      .AW    (AW),
      .DW    (2*PIX_W)
   ) u_line_ram (
      .clk   (clk),
      .raddr (in_col_q[AW-1:0]),
      .rdata (ram_rdata),
      .we    (step),
      .waddr (in_col_q[AW-1:0]),
      .wdata (ram_wdata)
   );

   // Step generation and the shifted window that the step would produce.
   always_comb begin
      out_free = ~win_valid_q | win_if.win_ready;
      unique case (state_q)
         ST_FILL:   in_ready = 1'b1;
         ST_STREAM: in_ready = out_free;
         default:   in_ready = 1'b0;
      endcase
      step_in    = win_if.in_valid & in_ready;
      step_flush = (state_q == ST_FLUSH) & out_free;
      step       = step_in | step_flush;
      step_pix   = step_flush ? '0 : win_if.in_pixel;
      emit       = step & (state_q != ST_FILL);

      win_nxt[0] = win_q[1];
      win_nxt[1] = win_q[2];
      win_nxt[2] = ram_rdata[2*PIX_W-1:PIX_W];
      win_nxt[3] = win_q[4];
      win_nxt[4] = win_q[5];
      win_nxt[5] = ram_rdata[PIX_W-1:0];
      win_nxt[6] = win_q[7];
      win_nxt[7] = win_q[8];
      win_nxt[8] = step_pix;

      ram_wdata  = {ram_rdata[PIX_W-1:0], step_pix};
   end

   always_comb begin
      state_d      = state_q;
      in_col_d     = in_col_q;
      in_row_d     = in_row_q;
      out_col_d    = out_col_q;
      out_row_d    = out_row_q;
      step_cnt_d   = step_cnt_q;
      win_d        = win_q;
      win_pixels_d = win_pixels_q;
      win_center_d = win_center_q;
      win_row_d    = win_row_q;
      win_col_d    = win_col_q;
      win_valid_d  = win_valid_q;
      win_last_d   = win_last_q;

      if (step) begin
         win_d = win_nxt;
         if (in_col_q == LAST_COL) begin
            in_col_d = '0;
            in_row_d = (in_row_q == LAST_ROW) ? '0 : in_row_q + 1'b1;
         end else begin
            in_col_d = in_col_q + 1'b1;
         end
      end

      // A new window may load in the same cycle the old one leaves.
      if (emit) begin
         win_pixels_d = pack_window(win_nxt, out_row_q == '0, out_row_q == LAST_ROW,
                                    out_col_q == '0, out_col_q == LAST_COL);
         win_center_d = win_nxt[4];
         win_row_d    = out_row_q;
         win_col_d    = out_col_q;
         win_valid_d  = 1'b1;
         win_last_d   = (out_row_q == LAST_ROW) && (out_col_q == LAST_COL);
         if (out_col_q == LAST_COL) begin
            out_col_d = '0;
            out_row_d = (out_row_q == LAST_ROW) ? '0 : out_row_q + 1'b1;
         end else begin
            out_col_d = out_col_q + 1'b1;
         end
      end else if (win_if.win_ready) begin
         win_valid_d = 1'b0;
      end

      unique case (state_q)
         ST_FILL: begin
            if (step) begin
               if (step_cnt_q == STEP_LAST) begin
                  state_d    = ST_STREAM;
                  step_cnt_d = '0;
               end else begin
                  step_cnt_d = step_cnt_q + 1'b1;
               end
            end
         end
         ST_STREAM: begin
            if (step_in && (in_col_q == LAST_COL) && (in_row_q == LAST_ROW)) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (step) begin
               if (step_cnt_q == STEP_LAST) begin
                  state_d    = ST_FILL;
                  step_cnt_d = '0;
                  in_col_d   = '0;
                  in_row_d   = '0;
                  out_col_d  = '0;
                  out_row_d  = '0;
               end else begin
                  step_cnt_d = step_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_FILL;
         in_col_q     <= '0;
         in_row_q     <= '0;
         out_col_q    <= '0;
         out_row_q    <= '0;
         step_cnt_q   <= '0;
         win_q        <= '0;
         win_pixels_q <= '0;
         win_center_q <= '0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         win_valid_q  <= 1'b0;
         win_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_col_q     <= in_col_d;
         in_row_q     <= in_row_d;
         out_col_q    <= out_col_d;
         out_row_q    <= out_row_d;
         step_cnt_q   <= step_cnt_d;
         win_q        <= win_d;
         win_pixels_q <= win_pixels_d;
         win_center_q <= win_center_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         win_valid_q  <= win_valid_d;
         win_last_q   <= win_last_d;
      end
   end

   assign win_if.in_ready   = in_ready;
   assign win_if.win_pixels = win_pixels_q;
   assign win_if.win_center = win_center_q;
   assign win_if.win_row    = win_row_q;
   assign win_if.win_col    = win_col_q;
   assign win_if.win_valid  = win_valid_q;
   assign win_if.frame_done = win_valid_q & win_if.win_ready & win_last_q;
   assign state_dbg         = state_q;

endmodule
